// File: rtl/md_engine.sv
// -----------------------------------------------------------------------------
// md_engine -- multiply/divide unit with HI/LO registers for the EX stage.
//
// Accepted mult/div operations run for a fixed number of cycles (MUL_CYCLES or
// DIV_CYCLES). The full-width result is computed at accept time into pending
// registers and committed to HI/LO on the edge that ends the last busy cycle.
// mthi/mtlo write HI/LO directly at the accept edge without going busy.
//
// Optional feature macro: MD_MADD_EN
//   defined   : op 6 (madd) / op 7 (maddu) accumulate the product into {hi,lo}
//   undefined : op 6 / op 7 are ignored
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   start     in   1      request, accepted only while idle
//   op        in   3      0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6 madd,7 maddu
//   src_a     in   WIDTH  multiplicand / dividend / mthi-mtlo data
//   src_b     in   WIDTH  multiplier / divisor
//   flush     in   1      abort the in-flight operation
//   busy      out  1      operation in flight
//   done      out  1      one-cycle pulse when hi/lo were just updated
//   div_zero  out  1      one-cycle pulse with done on divide by zero
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// -----------------------------------------------------------------------------
module md_engine #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Full 2*WIDTH product; operands are extended to 2*WIDTH first so the
    // truncated product equals the signed (or unsigned) product exactly.
    function automatic logic [2*WIDTH-1:0] mul_calc(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             is_signed
    );
        logic [2*WIDTH-1:0] ext_a;
        logic [2*WIDTH-1:0] ext_b;
        ext_a = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ext_a * ext_b;
    endfunction

    // Returns {remainder, quotient}. Signed division runs on magnitudes:
    // quotient truncates toward zero, remainder follows the dividend sign.
    // MIN / -1 falls out naturally as quotient MIN, remainder 0.
    function automatic logic [2*WIDTH-1:0] div_calc(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             is_signed
    );
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] rem;
        logic             neg_a;
        logic             neg_b;
        neg_a = is_signed & a[WIDTH-1];
        neg_b = is_signed & b[WIDTH-1];
        mag_a = neg_a ? (~a + ONE_W) : a;
        mag_b = neg_b ? (~b + ONE_W) : b;
        if (mag_b == ZERO_W) begin
            quo = ZERO_W;
            rem = ZERO_W;
        end else begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        if (neg_a ^ neg_b) begin
            quo = ~quo + ONE_W;
        end else begin
            quo = quo;
        end
        if (neg_a) begin
            rem = ~rem + ONE_W;
        end else begin
            rem = rem;
        end
        return {rem, quo};
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic               pend_acc_q, pend_acc_d;
    logic               pend_dz_q, pend_dz_d;

    // Next-state, counter, pending-result and HI/LO update logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dz_d       = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_d     = pend_q;
        pend_acc_d = pend_acc_q;
        pend_dz_d  = pend_dz_q;

        case (state_q)
            ST_IDLE: begin
                // flush in the same cycle as start blocks the request entirely
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d    = ST_RUN;
                            busy_d     = 1'b1;
                            cnt_d      = MUL_LOAD;
                            pend_d     = mul_calc(src_a, src_b, op == OP_MULT);
                            pend_acc_d = 1'b0;
                            pend_dz_d  = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d    = ST_RUN;
                            busy_d     = 1'b1;
                            cnt_d      = DIV_LOAD;
                            pend_d     = div_calc(src_a, src_b, op == OP_DIV);
                            pend_acc_d = 1'b0;
                            pend_dz_d  = (src_b == ZERO_W);
                        end
                        OP_MTHI: begin
                            hi_d = src_a;
                        end
                        OP_MTLO: begin
                            lo_d = src_a;
                        end
`ifdef MD_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            state_d    = ST_RUN;
                            busy_d     = 1'b1;
                            cnt_d      = MUL_LOAD;
                            pend_d     = mul_calc(src_a, src_b, op == OP_MADD);
                            pend_acc_d = 1'b1;
                            pend_dz_d  = 1'b0;
                        end
`endif
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    // abort wins even on what would be the commit edge
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                    if (pend_dz_q) begin
                        dz_d = 1'b1;
                    end else if (pend_acc_q) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                    end else begin
                        {hi_d, lo_d} = pend_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, pending result and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= ZERO_W;
            lo_q       <= ZERO_W;
            pend_q     <= {(2*WIDTH){1'b0}};
            pend_acc_q <= 1'b0;
            pend_dz_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_q     <= pend_d;
            pend_acc_q <= pend_acc_d;
            pend_dz_q  <= pend_dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_engine.sv
// -----------------------------------------------------------------------------
// tb_md_engine -- self-checking bench for md_engine (WIDTH=32, 5/10 cycles).
// Fixed vectors with hand-computed results, randomized ops against a
// behavioural model using 64-bit arithmetic, and hand-written sequences for
// flush, start-while-busy, asynchronous reset and madd/maddu.
// -----------------------------------------------------------------------------
module tb_md_engine;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = 32'd0;
    logic [W-1:0] src_b = 32'd0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    md_engine #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
        .src_b(src_b), .flush(flush), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] m_hi = 32'd0;
    logic [W-1:0] m_lo = 32'd0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        logic         exp_dz;
    } vec_t;
    vec_t vt[11];

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    function automatic int run_cycles(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return MC;
            3'd2, 3'd3: return DC;
`ifdef MD_MADD_EN
            3'd6, 3'd7: return MC;
`endif
            default: return 0;
        endcase
    endfunction

    // Architectural effect of one op on the model HI/LO; returns divide-by-zero.
    function automatic logic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     acc;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        model = 1'b0;
        case (o)
            3'd0: {m_hi, m_lo} = sa * sb;
            3'd1: {m_hi, m_lo} = ua * ub;
            3'd2: if (b == 32'd0) model = 1'b1;
                  else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd3: if (b == 32'd0) model = 1'b1;
                  else begin uq = ua / ub; ur = ua % ub; m_lo = uq[31:0]; m_hi = ur[31:0]; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MD_MADD_EN
            3'd6: begin acc = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = acc; end
            3'd7: begin acc = {m_hi, m_lo} + 64'(ua * ub); {m_hi, m_lo} = acc; end
`endif
            default: ;
        endcase
    endfunction

    // Issue one op, follow it to completion, compare against the model.
    task automatic exec(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic edz;
        int   cyc;
        int   want;
        want = run_cycles(o);
        edz  = model(o, a, b);
        @(negedge clk); start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk); start = 1'b0;
        if (want == 0) begin
            chk({tag, " busy"}, 64'(busy), 64'd0);
            chk({tag, " done"}, 64'(done), 64'd0);
        end else begin
            cyc = 0;
            while (busy === 1'b1 && cyc < 4 * DC) begin
                cyc++;
                @(negedge clk);
            end
            chk({tag, " cycles"}, 64'(cyc), 64'(want));
            chk({tag, " done"}, 64'(done), 64'd1);
            chk({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        end
        chk({tag, " hi"}, 64'(hi), 64'(m_hi));
        chk({tag, " lo"}, 64'(lo), 64'(m_lo));
        if (want != 0) begin
            @(negedge clk);
            chk({tag, " done pulse"}, 64'(done), 64'd0);
            chk({tag, " dz pulse"}, 64'(div_zero), 64'd0);
        end
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        int           sel, cyc, seen;
        logic         edz;

        vt[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'h11, 32'h22, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vt[1]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'h11, 32'h22, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[2]  = '{3'd3, 32'd7,        32'd2,        32'h11, 32'h22, 32'd1,        32'd3,        1'b0};
        vt[3]  = '{3'd3, 32'd5,        32'd0,        32'h1234, 32'h5678, 32'h1234, 32'h5678,     1'b1};
        vt[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h33, 32'h44, 32'd0,        32'h80000000, 1'b0};
        vt[5]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h33, 32'h44, 32'd1,        32'hFFFFFFFD, 1'b0};
        vt[6]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55, 32'h66, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h55, 32'h66, 32'h40000000, 32'd0,        1'b0};
        vt[8]  = '{3'd2, 32'd0,        32'd0,        32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB,     1'b1};
        vt[9]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h77, 32'h88, 32'd0,        32'd1,        1'b0};
        vt[10] = '{3'd3, 32'hFFFFFFFF, 32'd10,       32'h77, 32'h88, 32'd5,        32'd429496729, 1'b0};

        // reset state
        #12;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst div_zero", 64'(div_zero), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        @(negedge clk); reset = 1'b1;

        // fixed vectors
        for (int i = 0; i < 11; i++) begin
            exec($sformatf("v%0d mthi", i), 3'd4, vt[i].pre_hi, 32'd0);
            exec($sformatf("v%0d mtlo", i), 3'd5, vt[i].pre_lo, 32'd0);
            exec($sformatf("v%0d op", i), vt[i].op, vt[i].a, vt[i].b);
            chk($sformatf("v%0d tbl hi", i), 64'(hi), 64'(vt[i].exp_hi));
            chk($sformatf("v%0d tbl lo", i), 64'(lo), 64'(vt[i].exp_lo));
        end

        // randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 20));
            exec($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb);
        end

        // flush mid-multiply, with an ignored mthi while busy
        exec("fl mthi", 3'd4, 32'hCAFE, 32'd0);
        exec("fl mtlo", 3'd5, 32'hBEEF, 32'd0);
        @(negedge clk); start = 1'b1; op = 3'd1; src_a = 32'h80000000; src_b = 32'd2;
        @(negedge clk); start = 1'b0;
        chk("fl busy c1", 64'(busy), 64'd1);
        @(negedge clk); start = 1'b1; op = 3'd4; src_a = 32'hDEAD;
        @(negedge clk); start = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("fl busy", 64'(busy), 64'd0);
        chk("fl done", 64'(done), 64'd0);
        chk("fl hi", 64'(hi), 64'h0000CAFE);
        chk("fl lo", 64'(lo), 64'h0000BEEF);
        seen = 0;
        repeat (12) begin @(negedge clk); if (done) seen++; end
        chk("fl no late done", 64'(seen), 64'd0);
        chk("fl hi hold", 64'(hi), 64'h0000CAFE);

        // second start during busy is ignored
        @(negedge clk); start = 1'b1; op = 3'd0; src_a = 32'd6; src_b = 32'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk); start = 1'b0;
        cyc = 2;
        while (busy === 1'b1 && cyc < 4 * DC) begin cyc++; @(negedge clk); end
        chk("sb cycles", 64'(cyc), 64'd5);
        chk("sb done", 64'(done), 64'd1);
        chk("sb hi", 64'(hi), 64'd0);
        chk("sb lo", 64'(lo), 64'd42);
        m_hi = 32'd0; m_lo = 32'd42;

        // flush with start in idle: nothing accepted
        @(negedge clk); start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd3; flush = 1'b1;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        chk("fs busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("fs busy2", 64'(busy), 64'd0);
        chk("fs lo", 64'(lo), 64'd42);

        // asynchronous reset mid-divide
        exec("rs mthi", 3'd4, 32'h1111, 32'd0);
        @(negedge clk); start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("rs busy pre", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rs busy", 64'(busy), 64'd0);
        chk("rs hi", 64'(hi), 64'd0);
        chk("rs lo", 64'(lo), 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); reset = 1'b1;
        exec("rs multu", 3'd1, 32'h10000, 32'h10000);
        chk("rs multu hi", 64'(hi), 64'd1);
        chk("rs multu lo", 64'(lo), 64'd0);

        // maddu accumulate carry into hi (or ignored without the feature)
        exec("ma mthi", 3'd4, 32'd0, 32'd0);
        exec("ma mtlo", 3'd5, 32'hFFFFFFFF, 32'd0);
        exec("ma maddu", 3'd7, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        chk("ma hi", 64'(hi), 64'd1);
        chk("ma lo", 64'(lo), 64'd0);
`else
        repeat (3) @(negedge clk);
        chk("ma busy", 64'(busy), 64'd0);
        chk("ma hi", 64'(hi), 64'd0);
        chk("ma lo", 64'(lo), 64'hFFFFFFFF);
`endif
        edz = 1'b0;
        chk("end div_zero", 64'(div_zero), 64'(edz));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
